// File: rtl/fdivsqrt_r4_qds_constants_tracker.sv
// fdivsqrt_r4_qds_constants_tracker: registered radix-4 QDS constant generator for div/sqrt; FDIVSQRT_QDS_DIV_EN adds the division table
module fdivsqrt_r4_qds_constants_tracker #(
  parameter int QDS_W       = 7,
  parameter int FREEZE_ITER = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             is_sqrt_i,
  input  logic [3:0]       idx_i,
  input  logic             iter_en_i,
  input  logic             flush_i,
  output logic [QDS_W-1:0] m_n1_o,
  output logic [QDS_W-1:0] m_z0_o,
  output logic [QDS_W-1:0] m_p1_o,
  output logic [QDS_W-1:0] m_p2_o,
  output logic             cst_valid_o,
  output logic             frozen_o
);
  typedef enum logic [1:0] {S_IDLE, S_TRACK, S_HOLD} state_t;
  state_t      r_state;
  state_t      w_nxt;
  logic [3:0]  r_cnt;
  logic [27:0] r_cst;
  logic        w_sq_new;
  logic        w_sq_cur;
  logic        w_last;
  logic        w_track_iter;
  logic [27:0] w_tab;
  function automatic logic [27:0] f_pk(input int a, input int b, input int c, input int d);
    return {7'(a), 7'(b), 7'(c), 7'(d)};
  endfunction
  function automatic logic [27:0] f_tab(input logic i_sq, input logic [3:0] i_idx);
    logic [2:0] w_i;
    w_i = (i_sq & i_idx[3]) ? 3'd7 : i_idx[2:0];
`ifdef FDIVSQRT_QDS_DIV_EN
    if (!i_sq)
      case (w_i)
        3'd0: return f_pk(13, 4, -4, -12);
        3'd1: return f_pk(15, 6, -4, -14);
        3'd2: return f_pk(16, 6, -4, -15);
        3'd3: return f_pk(18, 6, -4, -16);
        3'd4: return f_pk(20, 8, -6, -18);
        3'd5: return f_pk(20, 8, -6, -20);
        3'd6: return f_pk(22, 8, -8, -20);
        default: return f_pk(24, 8, -8, -24);
      endcase
`endif
    case (w_i)
      3'd0: return f_pk(13, 4, -4, -12);
      3'd1: return f_pk(14, 5, -4, -14);
      3'd2: return f_pk(16, 6, -4, -16);
      3'd3: return f_pk(17, 6, -4, -16);
      3'd4: return f_pk(18, 6, -6, -18);
      3'd5: return f_pk(20, 8, -6, -20);
      3'd6: return f_pk(22, 8, -8, -20);
      default: return f_pk(23, 8, -8, -22);
    endcase
  endfunction
`ifdef FDIVSQRT_QDS_DIV_EN
  logic r_sqrt;
  assign w_sq_new = is_sqrt_i;
  assign w_sq_cur = r_sqrt;
  // mode captured at start, used for reloads while tracking
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_sqrt <= 1'b1;
    else if (!flush_i && start_i) r_sqrt <= is_sqrt_i;
`else
  logic w_unused_mode;
  assign w_unused_mode = is_sqrt_i;
  assign w_sq_new = 1'b1;
  assign w_sq_cur = 1'b1;
`endif
  assign w_tab        = f_tab(start_i ? w_sq_new : w_sq_cur, idx_i);
  assign w_last       = r_cnt == 4'(FREEZE_ITER - 1);
  assign w_track_iter = r_state == S_TRACK && iter_en_i;
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= S_IDLE;
    else r_state <= w_nxt;
  // next state: flush beats start beats iteration
  always_comb
    w_nxt = flush_i ? S_IDLE :
            start_i ? ((w_sq_new && FREEZE_ITER > 0) ? S_TRACK : S_HOLD) :
            (w_track_iter && w_last) ? S_HOLD : r_state;
  // constant registers and tracked-iteration counter; flush keeps constants
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_cnt <= '0;
      r_cst <= '0;
    end else if (flush_i) r_cnt <= '0;
    else if (start_i) begin
      r_cnt <= '0;
      r_cst <= w_tab;
    end else if (w_track_iter) begin
      r_cnt <= r_cnt + 4'd1;
      r_cst <= w_tab;
    end
  // outputs decoded from registers only, constants sign-extended to QDS_W
  always_comb begin
    cst_valid_o = r_state != S_IDLE;
    frozen_o    = r_state == S_HOLD;
    m_n1_o      = QDS_W'($signed(r_cst[27:21]));
    m_z0_o      = QDS_W'($signed(r_cst[20:14]));
    m_p1_o      = QDS_W'($signed(r_cst[13:7]));
    m_p2_o      = QDS_W'($signed(r_cst[6:0]));
  end
endmodule

// File: tb/tb_fdivsqrt_r4_qds_constants_tracker.sv
// tb_fdivsqrt_r4_qds_constants_tracker: directed + random checks of the QDS constant tracker against a table model
module tb_fdivsqrt_r4_qds_constants_tracker;
  localparam int FZ = 2;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_i = 1'b0, is_sqrt_i = 1'b0, iter_en_i = 1'b0, flush_i = 1'b0;
  logic [3:0] idx_i = '0;
  logic [6:0] n1a, z0a, p1a, p2a;
  logic [8:0] n1b, z0b, p1b, p2b;
  logic va, fa, vb, fb;
  int total = 0;
  int bad = 0;
  int sq_t[8][4] = '{'{13,4,-4,-12}, '{14,5,-4,-14}, '{16,6,-4,-16}, '{17,6,-4,-16},
                     '{18,6,-6,-18}, '{20,8,-6,-20}, '{22,8,-8,-20}, '{23,8,-8,-22}};
  int dv_t[8][4] = '{'{13,4,-4,-12}, '{15,6,-4,-14}, '{16,6,-4,-15}, '{18,6,-4,-16},
                     '{20,8,-6,-18}, '{20,8,-6,-20}, '{22,8,-8,-20}, '{24,8,-8,-24}};
  int m_c[4] = '{0, 0, 0, 0};
  bit m_v = 0, m_f = 0, m_sq = 1;
  int m_left = 0;

  fdivsqrt_r4_qds_constants_tracker #(.QDS_W(7), .FREEZE_ITER(FZ)) u_a (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .is_sqrt_i(is_sqrt_i), .idx_i(idx_i),
    .iter_en_i(iter_en_i), .flush_i(flush_i), .m_n1_o(n1a), .m_z0_o(z0a), .m_p1_o(p1a),
    .m_p2_o(p2a), .cst_valid_o(va), .frozen_o(fa));
  fdivsqrt_r4_qds_constants_tracker #(.QDS_W(9), .FREEZE_ITER(FZ)) u_b (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .is_sqrt_i(is_sqrt_i), .idx_i(idx_i),
    .iter_en_i(iter_en_i), .flush_i(flush_i), .m_n1_o(n1b), .m_z0_o(z0b), .m_p1_o(p1b),
    .m_p2_o(p2b), .cst_valid_o(vb), .frozen_o(fb));

  always #5 clk = ~clk;

  task automatic load(input bit sq, input logic [3:0] ix);
    for (int k = 0; k < 4; k++)
      m_c[k] = sq ? (ix[3] ? sq_t[7][k] : sq_t[ix[2:0]][k]) : dv_t[ix[2:0]][k];
  endtask

  task automatic model(input bit st, input bit sq, input logic [3:0] ix, input bit it, input bit fl);
    if (fl) begin
      m_v = 0;
      m_f = 0;
    end else if (st) begin
`ifdef FDIVSQRT_QDS_DIV_EN
      m_sq = sq;
`else
      m_sq = 1;
`endif
      load(m_sq, ix);
      m_v = 1;
      m_left = m_sq ? FZ : 0;
      m_f = m_left == 0;
    end else if (it && m_v && !m_f) begin
      load(m_sq, ix);
      m_left--;
      m_f = m_left == 0;
    end
  endtask

  task automatic chk(input string tag);
    logic [6:0] a[4];
    logic [8:0] b[4];
    a = '{n1a, z0a, p1a, p2a};
    b = '{n1b, z0b, p1b, p2b};
    for (int k = 0; k < 4; k++) begin
      total++;
      assert (a[k] === 7'(m_c[k])) else begin
        bad++;
        $error("FAIL %s w7 c%0d got=%b exp=%b", tag, k, a[k], 7'(m_c[k]));
      end
      total++;
      assert (b[k] === 9'(m_c[k])) else begin
        bad++;
        $error("FAIL %s w9 c%0d got=%b exp=%b", tag, k, b[k], 9'(m_c[k]));
      end
    end
    total++;
    assert (va === m_v && vb === m_v) else begin
      bad++;
      $error("FAIL %s valid got=%b/%b exp=%b", tag, va, vb, m_v);
    end
    total++;
    assert (fa === m_f && fb === m_f) else begin
      bad++;
      $error("FAIL %s frozen got=%b/%b exp=%b", tag, fa, fb, m_f);
    end
  endtask

  task automatic step(input bit st, input bit sq, input logic [3:0] ix, input bit it, input bit fl, input string tag);
    start_i = st;
    is_sqrt_i = sq;
    idx_i = ix;
    iter_en_i = it;
    flush_i = fl;
    @(posedge clk);
    model(st, sq, ix, it, fl);
    #1;
    chk(tag);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      start_i = 1'($urandom);
      is_sqrt_i = 1'($urandom);
      idx_i = 4'($urandom);
      iter_en_i = 1'($urandom);
      flush_i = 1'($urandom);
      @(posedge clk);
      #1;
      chk("reset");
    end
    rst_n = 1'b1;
    step(1, 1, 4'b0000, 0, 0, "start_sq0");
    total++;
    assert (n1a === 7'b0001101 && z0a === 7'b0000100 && p1a === 7'b1111100 && p2a === 7'b1110100) else begin
      bad++;
      $error("FAIL lit7 got=%b/%b/%b/%b exp=0001101/0000100/1111100/1110100", n1a, z0a, p1a, p2a);
    end
    total++;
    assert (p2b === 9'b111110100 && n1b === 9'b000001101) else begin
      bad++;
      $error("FAIL lit9 got=%b/%b exp=111110100/000001101", p2b, n1b);
    end
    step(0, 0, 4'b0100, 1, 0, "trk1");
    step(0, 0, 4'b1000, 1, 0, "trk2_freeze");
    step(0, 0, 4'b0000, 1, 0, "hold_ign1");
    step(0, 1, 4'b0011, 1, 0, "hold_ign2");
    step(1, 0, 4'b0111, 0, 0, "div7");
    step(0, 0, 4'b0010, 1, 0, "div_iter");
    step(1, 0, 4'b0001, 0, 0, "div1");
    step(1, 1, 4'b0010, 0, 0, "restart_sq");
    step(0, 1, 4'b0101, 1, 0, "trk_a");
    step(0, 1, 4'b0110, 0, 1, "flush_trk");
    step(0, 1, 4'b0110, 1, 0, "idle_iter");
    step(1, 1, 4'b0011, 0, 1, "start_flush");
    step(1, 1, 4'b0001, 0, 0, "start_b");
    step(0, 1, 4'b0110, 1, 0, "trk_b1");
    step(1, 1, 4'b0111, 1, 0, "start_iter");
    step(0, 1, 4'b1010, 1, 0, "cnt_restart");
    step(0, 1, 4'b0100, 1, 0, "freeze_b");
    step(1, 1, 4'b0101, 0, 0, "restart_hold");
    step(0, 1, 4'b0110, 1, 0, "trk_c");
    #2;
    rst_n = 1'b0;
    #1;
    m_c = '{0, 0, 0, 0};
    m_v = 0;
    m_f = 0;
    chk("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 7) == 0), 1'($urandom), 4'($urandom), 1'($urandom),
           1'($urandom_range(0, 15) == 0), "rand");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fdivsqrt_r4_qds_constants_tracker.md
# fdivsqrt_r4_qds_constants_tracker

Registered, mode-aware generator of the four radix-4 quotient/root-digit selection constants for the shared small floating-point div/sqrt iteration loop. It supports sqrt and division from one table-select index and a parametrised output width. In sqrt mode it re-selects constants while the early partial root is still settling, then freezes them for the remaining iterations. It sits between the operand/partial-root registers and the QDS comparators of the iteration datapath.

## Interface
Parameters:
- QDS_W, default 7: width of each constant output; must be ≥ 7. Values are two's complement, sign-extended from the 7-bit base encoding, with the binary point kept between bits [3] and [2] of the base.
- FREEZE_ITER, default 2: number of sqrt iterations during which constants are re-selected; range 0..15.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- start_i  in  1  begin an operation; captures mode and index.
- is_sqrt_i  in  1  1 = sqrt, 0 = division; sampled only with start_i.
- idx_i  in  4  sqrt mode: {a0, a2, a3, a4} of the partial root. Div mode: {0, d[-2:-4]} of the normalised divisor, with bit 3 ignored.
- iter_en_i  in  1  one iteration completes this cycle.
- flush_i  in  1  abort and return to IDLE.
- m_n1_o, m_z0_o, m_p1_o, m_p2_o  out  QDS_W each  negated constants −m[−1], −m[0], −m[+1], −m[+2].
- cst_valid_o  out  1  constants valid for use.
- frozen_o  out  1  constants locked for the rest of the operation.

## Operation
- Sqrt table, as −m[−1] / −m[0] / −m[+1] / −m[+2] for {a2,a3,a4} = i with a0 = 0:
  - i0: 13/4/−4/−12
  - i1: 14/5/−4/−14
  - i2: 16/6/−4/−16
  - i3: 17/6/−4/−16
  - i4: 18/6/−6/−18
  - i5: 20/8/−6/−20
  - i6: 22/8/−8/−20
  - i7: 23/8/−8/−22
  - a0 = 1 uses the i7 values regardless of a2..a4.
- Div table, same order, indexed by d[−2:−4] = i:
  - i0: 13/4/−4/−12
  - i1: 15/6/−4/−14
  - i2: 16/6/−4/−15
  - i3: 18/6/−4/−16
  - i4: 20/8/−6/−18
  - i5: 20/8/−6/−20
  - i6: 22/8/−8/−20
  - i7: 24/8/−8/−24
- FSM states: IDLE, TRACK, HOLD. A 4-bit counter counts tracked iterations.
- Event priority: flush_i > start_i > iter_en_i.
- IDLE:
  - start_i: load constants from idx_i in the captured mode and clear the counter.
  - Next state is TRACK if sqrt and FREEZE_ITER > 0, otherwise HOLD.
- TRACK:
  - Each iter_en_i reloads the constants from the current idx_i and increments the counter.
  - On the FREEZE_ITER-th iter_en_i, load the constants, then go to HOLD.
- HOLD:
  - Constants are unchanged; iter_en_i is ignored.
  - The state persists until flush_i or start_i.
- start_i in TRACK or HOLD restarts exactly as from IDLE.
- flush_i in any state: go to IDLE, clear the counter, deassert cst_valid_o and frozen_o, and keep the constant registers at their last values.
- cst_valid_o = state ≠ IDLE. frozen_o = state == HOLD.

## Timing
- All outputs are registered. Reset values:
  - all constants 0
  - cst_valid_o = 0, frozen_o = 0
  - state IDLE, counter 0
- Latency: constants selected by idx_i at cycle N (start_i or iter_en_i) appear at cycle N+1.
- Simultaneous start_i and iter_en_i: start_i wins and the counter restarts at 0.
- flush_i together with start_i: flush_i wins, and the FSM is IDLE next cycle.
- Reset asserted mid-operation clears everything immediately, with no clock needed.
- No combinational path from any input to any output.

## Configuration
- Macro FDIVSQRT_QDS_DIV_EN:
  - Defined: the division table is present and is_sqrt_i selects the mode.
  - Undefined: the division table is removed, is_sqrt_i is ignored and treated as 1, and only the sqrt table is built.

## Test plan
- Reset: hold rst_n = 0 with random inputs → all constants 0, cst_valid_o = 0, frozen_o = 0. Release, then start_i, sqrt, idx = 4'b0000 → next cycle m_n1_o = 7'b0001101, m_z0_o = 7'b0000100, m_p1_o = 7'b1111100, m_p2_o = 7'b1110100, cst_valid_o = 1, frozen_o = 0.
- Sqrt tracking with FREEZE_ITER = 2:
  - Start with idx 0000.
  - iter_en_i with idx 0100 → 18/6/−6/−18.
  - iter_en_i with idx 1000 → 23/8/−8/−22 and frozen_o = 1.
  - Further iter_en_i with idx 0000 leaves outputs unchanged.
- Div mode (macro defined): start_i, is_sqrt_i = 0, idx = 4'b0111 → 24/8/−8/−24 and frozen_o = 1 one cycle later.
- Sign-extension: QDS_W = 9, sqrt, idx 0000 → m_p2_o = 9'b111110100 and m_n1_o = 9'b000001101.
- Flush and restart:
  - flush_i during TRACK → cst_valid_o = 0 next cycle, constants held.
  - start_i and flush_i in the same cycle → IDLE.
  - start_i in HOLD with new idx → reloads and re-enters TRACK.
- Macro undefined: start_i with is_sqrt_i = 0 and idx 0001 → sqrt values 14/5/−4/−14 and TRACK entered.
